mem_disp_reader: RTL

- Consumer of the 8-bit RAM address produced by the address sequencer.
- Detects each new address and issues a single read to the 256x16 display RAM.
- Captures the returned 16-bit word and time-multiplexes it as four hex digits on the common-anode 7-segment display.
- Sits between the address sequencer, the RAM read port and the board display pins.

---
 rtl/mem_disp_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_disp_reader.sv
// Fetches the RAM word for each new sequencer address and shows it as four
// multiplexed hex digits on a common-anode 7-segment display.
module mem_disp_reader #(
  parameter int REFRESH_DIV = 50000,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  addr,
  output logic [7:0]  ram_addr,
  output logic        ram_rd,
  input  logic [15:0] ram_dout,
  output logic        busy,
  output logic [15:0] data_q,
  output logic [3:0]  an,
  output logic [6:0]  seg
);
  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam int RW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_nxt;
  logic [7:0]      addr_q;
  logic            force_fetch;
  logic [CW-1:0]   wcnt;
  logic            fetch, capture, rd_nxt, busy_nxt;
  logic [RW-1:0]   rcnt;
  logic [1:0]      idx;
  logic [3:0]      nib;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (addr != addr_q || force_fetch) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (wcnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so their next values follow the next state.
  always_comb begin
    fetch    = (state == IDLE) && (state_nxt == REQ);
    capture  = (state == WAIT) && (wcnt == CW'(1));
    rd_nxt   = (state_nxt == REQ);
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr    <= '0;
      ram_rd      <= 1'b0;
      busy        <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      force_fetch <= 1'b1;
      wcnt        <= '0;
    end else begin
      ram_rd <= rd_nxt;
      busy   <= busy_nxt;
      if (fetch) begin
        ram_addr    <= addr;
        addr_q      <= addr;
        force_fetch <= 1'b0;
      end
      if (state == REQ)       wcnt <= CW'(RD_LATENCY);
      else if (state == WAIT) wcnt <= wcnt - CW'(1);
      if (capture) data_q <= ram_dout;
    end
  end

  assign nib = data_q[idx*4 +: 4];

  // Refresh timing runs free of the fetch FSM; an/seg lag idx by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
      an   <= 4'b1111;
      seg  <= 7'b1111111;
    end else begin
      if (rcnt == RW'(REFRESH_DIV - 1)) begin
        rcnt <= '0;
        idx  <= idx + 2'd1;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
      an  <= ~(4'b0001 << idx);
      seg <= hex7(nib);
    end
  end
endmodule
